level_port_arbiter: RTL

// Shares one single-port, 1-cycle-read-latency level tile memory among the display path and
// NUM_REQ collision requesters (player, blade, lizard). Replaces per-client combinational lookups.

---
 rtl/level_port_arbiter_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/level_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/level_port_arbiter_pkg.sv
// rtl/level_port_arbiter_pkg.sv - screen geometry and level block-type definitions
package sk_defs;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int TILE_SHIFT = 5;
    localparam int COORD_W    = 10;

    // Block types stored in the level tile memory; BLK_OOB never appears in memory,
    // it is synthesised for coordinates outside the visible screen.
    typedef enum logic [2:0] {
        BLK_EMPTY    = 3'd0,
        BLK_BRICK    = 3'd1,
        BLK_PLATFORM = 3'd2,
        BLK_SPIKE    = 3'd3,
        BLK_LADDER   = 3'd4,
        BLK_COIN     = 3'd5,
        BLK_EXIT     = 3'd6,
        BLK_OOB      = 3'd7
    } blockType_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal last-winner pointer
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winIdx;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan from the slot after the last winner so every requester gets its turn
    always_comb begin
        gnt    = '0;
        winIdx = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                winIdx    = cand;
                found     = 1'b1;
            end
        end
    end

    // Pointer moves only when a requester actually wins; reset makes requester 0 first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (found) begin
            ptr <= winIdx;
        end
    end

endmodule

// File: rtl/level_port_arbiter.sv
// rtl/level_port_arbiter.sv - shares the level tile memory between display and collision clients
module level_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_W     = 3,
    parameter int TILE_SHIFT = sk_defs::TILE_SHIFT,
    parameter int COLS       = 20,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  disp_pix_en,
    input  logic                  disp_active,
    input  logic [9:0]            disp_x,
    input  logic [9:0]            disp_y,
    output logic [DATA_W-1:0]     disp_data,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*10-1:0] req_x,
    input  logic [NUM_REQ*10-1:0] req_y,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata
);

    import sk_defs::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Travels alongside each access so the result lands at the right client
    typedef struct packed {
        logic             valid;
        logic             disp;
        logic             oob;
        logic [IDX_W-1:0] idx;
    } pipeTag_t;

    logic               dispOwns;
    logic [NUM_REQ-1:0] arbGnt;
    logic [IDX_W-1:0]   winIdx;
    logic [9:0]         selX;
    logic [9:0]         selY;
    logic               selOob;
    logic [ADDR_W-1:0]  tileRow;
    logic [ADDR_W-1:0]  tileCol;
    logic [ADDR_W-1:0]  selAddr;
    pipeTag_t           tag0;
    pipeTag_t           tag1;
    pipeTag_t           tag2;

    // Display always wins its pixel-tick slot; collision clients only see the other cycles
    assign dispOwns = disp_pix_en && disp_active;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) uArb (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .en     (reset_n && !dispOwns),
        .gnt    (arbGnt)
    );

    assign gnt = arbGnt;

    // Owner mux: coordinates and index of whoever owns this cycle
    always_comb begin
        selX   = disp_x;
        selY   = disp_y;
        winIdx = '0;
        if (!dispOwns) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (arbGnt[i]) begin
                    selX   = req_x[10*i +: 10];
                    selY   = req_y[10*i +: 10];
                    winIdx = IDX_W'(i);
                end
            end
        end
    end

    assign selOob  = (selX >= 10'(SCREEN_W)) || (selY >= 10'(SCREEN_H));
    assign tileRow = ADDR_W'(selY >> TILE_SHIFT);
    assign tileCol = ADDR_W'(selX >> TILE_SHIFT);
    assign selAddr = tileRow * ADDR_W'(COLS) + tileCol;

    assign tag0.valid = dispOwns || (|arbGnt);
    assign tag0.disp  = dispOwns;
    assign tag0.oob   = selOob;
    assign tag0.idx   = winIdx;

    // Stage 1: issue the memory read; out-of-screen slots keep the memory idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag1     <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            tag1   <= tag0;
            mem_en <= tag0.valid && !tag0.oob;
            if (tag0.valid && !tag0.oob) begin
                mem_addr <= selAddr;
            end
        end
    end

    // Stage 2: wait out the single-cycle memory latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag2 <= '0;
        end else begin
            tag2 <= tag1;
        end
    end

    // Stage 3: register the result and steer it to the display or the tagged requester
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid    <= '0;
            rdata     <= DATA_W'(BLK_EMPTY);
            disp_data <= DATA_W'(BLK_EMPTY);
        end else begin
            rvalid <= '0;
            if (tag2.valid) begin
                if (tag2.disp) begin
                    disp_data <= tag2.oob ? DATA_W'(BLK_OOB) : mem_rdata;
                end else begin
                    rvalid[tag2.idx] <= 1'b1;
                    rdata            <= tag2.oob ? DATA_W'(BLK_OOB) : mem_rdata;
                end
            end
        end
    end

endmodule
